// File: rtl/cmd_cntrl_pkg.sv
// Shared types and constants for the barcode-guided command sequencer.
package cmd_cntrl_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_MOVING = 1'b1
    } state_t;

    localparam logic [1:0] OP_STOP        = 2'b00;
    localparam logic [1:0] OP_GO          = 2'b01;
    localparam logic [1:0] ID_TAG_STATION = 2'b00;

    // Only IDs tagged as a station can terminate a transit.
    function automatic logic id_match(input logic [7:0] id, input logic [5:0] dest);
        return (id[7:6] == ID_TAG_STATION) && (id[5:0] == dest);
    endfunction

endpackage

// File: rtl/cmd_cntrl_if.sv
// Command/ID handshake and motion outputs of cmd_cntrl, bundled for port use.
interface cmd_cntrl_if;

    logic [7:0] cmd;
    logic       cmd_rdy;
    logic       clr_cmd_rdy;
    logic [7:0] ID;
    logic       ID_vld;
    logic       clr_ID_vld;
    logic       OK2Move;
    logic       go;
    logic       in_transit;
    logic       buzz;
    logic       buzz_n;

    modport master (
        output cmd, cmd_rdy, ID, ID_vld, OK2Move,
        input  clr_cmd_rdy, clr_ID_vld, go, in_transit, buzz, buzz_n
    );

    modport slave (
        input  cmd, cmd_rdy, ID, ID_vld, OK2Move,
        output clr_cmd_rdy, clr_ID_vld, go, in_transit, buzz, buzz_n
    );

endinterface

// File: rtl/cmd_cntrl_buzz_gen.sv
// Piezo square-wave generator: toggles every BUZZ_DIV cycles while en is high.
module buzz_gen #(
    parameter int BUZZ_DIV = 12500
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic buzz,
    output logic buzz_n
);

    localparam int CW = (BUZZ_DIV > 2) ? $clog2(BUZZ_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BUZZ_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic          buzz_q;

    // Dropping en silences the piezo and restarts the half-period from zero.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt_q  <= '0;
            buzz_q <= 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q  <= '0;
            buzz_q <= ~buzz_q;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    assign buzz   = buzz_q;
    assign buzz_n = ~buzz_q;

endmodule

// File: rtl/cmd_cntrl.sv
// Command sequencer: latches a destination station and runs until its ID is read.
// Optional piezo warning while blocked in transit: define CMD_CNTRL_BUZZ_EN.
module cmd_cntrl
    import cmd_cntrl_pkg::*;
#(
    parameter int BUZZ_DIV = 12500
) (
    input  logic        clk,
    input  logic        rst,
    cmd_cntrl_if.slave  bus
);

    if (BUZZ_DIV < 2) begin : g_div_check
        $error("BUZZ_DIV must be at least 2");
    end

    state_t     state_q;
    logic [5:0] dest_q;
    logic       in_transit_q;
    logic       buzz_w;
    logic       buzz_n_w;

    // Every request is consumed in either state, so the clears are plain Mealy pulses.
    assign bus.clr_cmd_rdy = bus.cmd_rdy & ~rst;
    assign bus.clr_ID_vld  = bus.ID_vld  & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            dest_q       <= '0;
            in_transit_q <= 1'b0;
        end else if (bus.cmd_rdy) begin
            // A command wins a collision; the simultaneous ID is dropped unexamined.
            case (bus.cmd[7:6])
                OP_GO: begin
                    dest_q       <= bus.cmd[5:0];
                    state_q      <= ST_MOVING;
                    in_transit_q <= 1'b1;
                end
                OP_STOP: begin
                    state_q      <= ST_IDLE;
                    in_transit_q <= 1'b0;
                end
                default: ;
            endcase
        end else if (bus.ID_vld && state_q == ST_MOVING && id_match(bus.ID, dest_q)) begin
            state_q      <= ST_IDLE;
            in_transit_q <= 1'b0;
        end
    end

    assign bus.in_transit = in_transit_q;
    assign bus.go         = in_transit_q & bus.OK2Move;

`ifdef CMD_CNTRL_BUZZ_EN
    buzz_gen #(
        .BUZZ_DIV (BUZZ_DIV)
    ) u_buzz_gen (
        .clk    (clk),
        .rst    (rst),
        .en     (in_transit_q & ~bus.OK2Move),
        .buzz   (buzz_w),
        .buzz_n (buzz_n_w)
    );
`else
    assign buzz_w   = 1'b0;
    assign buzz_n_w = 1'b1;
`endif

    assign bus.buzz   = buzz_w;
    assign bus.buzz_n = buzz_n_w;

endmodule

// File: tb/tb_cmd_cntrl.sv
// Directed bench for cmd_cntrl: handshakes, stop/retarget, collisions, buzzer, reset.
module tb_cmd_cntrl;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    cmd_cntrl_if bus ();

    cmd_cntrl #(
        .BUZZ_DIV (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents a command for one edge, as a source that drops cmd_rdy on its clearing edge.
    task automatic send_cmd(input string tag, input logic [7:0] c, input logic exp_transit);
        @(negedge clk);
        bus.cmd     = c;
        bus.cmd_rdy = 1'b1;
        #1;
        chk({tag, "_clr"}, {7'd0, bus.clr_cmd_rdy}, 8'd1);
        @(posedge clk);
        #1;
        bus.cmd_rdy = 1'b0;
        #1;
        chk({tag, "_clr_drop"}, {7'd0, bus.clr_cmd_rdy}, 8'd0);
        chk({tag, "_transit"}, {7'd0, bus.in_transit}, {7'd0, exp_transit});
        $display("cmd   %s cmd=%02h in_transit=%0b go=%0b", tag, c, bus.in_transit, bus.go);
    endtask

    task automatic send_id(input string tag, input logic [7:0] id, input logic exp_transit);
        @(negedge clk);
        bus.ID     = id;
        bus.ID_vld = 1'b1;
        #1;
        chk({tag, "_clr"}, {7'd0, bus.clr_ID_vld}, 8'd1);
        @(posedge clk);
        #1;
        bus.ID_vld = 1'b0;
        #1;
        chk({tag, "_clr_drop"}, {7'd0, bus.clr_ID_vld}, 8'd0);
        chk({tag, "_transit"}, {7'd0, bus.in_transit}, {7'd0, exp_transit});
        $display("id    %s ID=%02h in_transit=%0b go=%0b", tag, id, bus.in_transit, bus.go);
    endtask

    logic exp_buzz;

    initial begin
        errors      = 0;
        checks      = 0;
        rst         = 1'b1;
        bus.cmd     = 8'h00;
        bus.cmd_rdy = 1'b0;
        bus.ID      = 8'h00;
        bus.ID_vld  = 1'b0;
        bus.OK2Move = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_transit", {7'd0, bus.in_transit}, 8'd0);
        chk("rst_go",      {7'd0, bus.go},         8'd0);
        chk("rst_clr_cmd", {7'd0, bus.clr_cmd_rdy}, 8'd0);
        chk("rst_clr_id",  {7'd0, bus.clr_ID_vld}, 8'd0);
        chk("rst_buzz",    {7'd0, bus.buzz},       8'd0);
        chk("rst_buzz_n",  {7'd0, bus.buzz_n},     8'd1);
        $display("reset in_transit=%0b go=%0b buzz=%0b", bus.in_transit, bus.go, bus.buzz);
        rst = 1'b0;

        // Go to station 5; in_transit must still be low during the accepting cycle.
        @(negedge clk);
        bus.cmd     = 8'h45;
        bus.cmd_rdy = 1'b1;
        #1;
        chk("go_clr",          {7'd0, bus.clr_cmd_rdy}, 8'd1);
        chk("go_transit_same", {7'd0, bus.in_transit},  8'd0);
        @(posedge clk);
        #1;
        bus.cmd_rdy = 1'b0;
        #1;
        chk("go_clr_drop", {7'd0, bus.clr_cmd_rdy}, 8'd0);
        chk("go_transit",  {7'd0, bus.in_transit},  8'd1);
        chk("go_go",       {7'd0, bus.go},          8'd1);
        $display("cmd   go cmd=45 in_transit=%0b go=%0b", bus.in_transit, bus.go);

        // Non-matching IDs, then OK2Move gating, then the matching station.
        send_id("id03", 8'h03, 1'b1);
        send_id("id45_tag", 8'h45, 1'b1);
        @(negedge clk);
        bus.OK2Move = 1'b0;
        #1;
        chk("blocked_go",      {7'd0, bus.go},         8'd0);
        chk("blocked_transit", {7'd0, bus.in_transit}, 8'd1);
        @(negedge clk);
        bus.OK2Move = 1'b1;
        #1;
        chk("unblocked_go", {7'd0, bus.go}, 8'd1);
        send_id("id05_match", 8'h05, 1'b0);
        chk("match_go", {7'd0, bus.go}, 8'd0);

        // Stop, then retarget to 6'h0A.
        send_cmd("go45_a", 8'h45, 1'b1);
        send_cmd("stop",   8'h00, 1'b0);
        send_cmd("go45_b", 8'h45, 1'b1);
        send_cmd("go4a",   8'h4A, 1'b1);
        send_id("old05", 8'h05, 1'b1);
        send_id("new0a", 8'h0A, 1'b0);

        // Collisions: the command acts, the ID is never compared.
        send_cmd("go45_c", 8'h45, 1'b1);
        @(negedge clk);
        bus.cmd = 8'hC7; bus.cmd_rdy = 1'b1;
        bus.ID  = 8'h05; bus.ID_vld  = 1'b1;
        #1;
        chk("coll_rsv_clr_cmd", {7'd0, bus.clr_cmd_rdy}, 8'd1);
        chk("coll_rsv_clr_id",  {7'd0, bus.clr_ID_vld},  8'd1);
        @(posedge clk);
        #1;
        bus.cmd_rdy = 1'b0; bus.ID_vld = 1'b0;
        #1;
        chk("coll_rsv_transit", {7'd0, bus.in_transit}, 8'd1);
        $display("coll  cmd=C7 ID=05 in_transit=%0b", bus.in_transit);
        @(negedge clk);
        bus.cmd = 8'h00; bus.cmd_rdy = 1'b1;
        bus.ID  = 8'h05; bus.ID_vld  = 1'b1;
        #1;
        chk("coll_stop_clr_cmd", {7'd0, bus.clr_cmd_rdy}, 8'd1);
        chk("coll_stop_clr_id",  {7'd0, bus.clr_ID_vld},  8'd1);
        @(posedge clk);
        #1;
        bus.cmd_rdy = 1'b0; bus.ID_vld = 1'b0;
        #1;
        chk("coll_stop_transit", {7'd0, bus.in_transit}, 8'd0);
        $display("coll  cmd=00 ID=05 in_transit=%0b", bus.in_transit);

        // Drain in IDLE, reserved opcodes in IDLE.
        send_id("drain05", 8'h05, 1'b0);
        send_cmd("rsv_c7", 8'hC7, 1'b0);
        send_cmd("rsv_85", 8'h85, 1'b0);

        // Blocked buzzer: with BUZZ_DIV=4 it toggles every 4 edges.
        send_cmd("go45_d", 8'h45, 1'b1);
        @(negedge clk);
        bus.OK2Move = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
`ifdef CMD_CNTRL_BUZZ_EN
            exp_buzz = ((n / 4) % 2) == 1;
`else
            exp_buzz = 1'b0;
`endif
            chk("buzz",   {7'd0, bus.buzz},   {7'd0, exp_buzz});
            chk("buzz_n", {7'd0, bus.buzz_n}, {7'd0, ~exp_buzz});
            chk("buzz_go", {7'd0, bus.go}, 8'd0);
            $display("buzz  edge=%0d buzz=%0b buzz_n=%0b", n, bus.buzz, bus.buzz_n);
        end
        bus.OK2Move = 1'b1;
        @(negedge clk);
        chk("buzz_off",   {7'd0, bus.buzz},   8'd0);
        chk("buzz_n_off", {7'd0, bus.buzz_n}, 8'd1);
        chk("buzz_off_go", {7'd0, bus.go}, 8'd1);
        $display("buzz  released buzz=%0b go=%0b", bus.buzz, bus.go);

        // Reset mid-transit with a matching ID and a GO pending.
        @(negedge clk);
        rst = 1'b1;
        bus.ID = 8'h05; bus.ID_vld = 1'b1;
        bus.cmd = 8'h4A; bus.cmd_rdy = 1'b1;
        #1;
        chk("rstm_clr_id",  {7'd0, bus.clr_ID_vld},  8'd0);
        chk("rstm_clr_cmd", {7'd0, bus.clr_cmd_rdy}, 8'd0);
        @(negedge clk);
        chk("rstm_transit", {7'd0, bus.in_transit},  8'd0);
        chk("rstm_go",      {7'd0, bus.go},          8'd0);
        chk("rstm_clr_id2", {7'd0, bus.clr_ID_vld},  8'd0);
        chk("rstm_buzz",    {7'd0, bus.buzz},        8'd0);
        chk("rstm_buzz_n",  {7'd0, bus.buzz_n},      8'd1);
        $display("rst   mid-transit in_transit=%0b go=%0b", bus.in_transit, bus.go);
        bus.ID_vld = 1'b0; bus.cmd_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_transit", {7'd0, bus.in_transit}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmd_cntrl.md
# cmd_cntrl

Command sequencer for the follower's barcode-guided motion. Accepts 8-bit commands from the UART command path, latches a destination station ID, and enables the motion controller (`go`) while in transit. It consumes IDs from the `barcode` decoder through its `ID_vld`/`clr_ID_vld` handshake and stops the follower when the matching station is read. It also drives the piezo warning while the follower is in transit but blocked.

## Interface
- `BUZZ_DIV`, 12500: clock cycles per piezo half-period (12500 gives 2 kHz at 50 MHz); must be ≥ 2.
- `clk` input 1: system clock; all state updates on posedge.
- `rst` input 1: synchronous, active-high reset.
- `cmd` input 8: command word; [7:6] opcode, [5:0] destination station ID.
- `cmd_rdy` input 1: level; `cmd` valid, held until `clr_cmd_rdy` is seen.
- `clr_cmd_rdy` output 1: one-cycle pulse consuming the current command.
- `ID` input 8: station ID from `barcode`; [7:6] must be 2'b00 for a valid station.
- `ID_vld` input 1: level; `ID` valid, held until `clr_ID_vld` is seen.
- `clr_ID_vld` output 1: one-cycle pulse consuming the current ID.
- `OK2Move` input 1: no obstacle; motion permitted.
- `go` output 1: motion enable to the motion controller.
- `in_transit` output 1: a destination is active.
- `buzz` output 1: piezo drive.
- `buzz_n` output 1: complement of `buzz`.

## Operation
- Opcodes: `OP_STOP`=2'b00, `OP_GO`=2'b01; 2'b10 and 2'b11 are reserved and are consumed without effect.
- Registers: `state` {IDLE, MOVING}, `dest_ID[5:0]`.
- IDLE (`in_transit`=0):
  - When `cmd_rdy`=1, pulse `clr_cmd_rdy`.
  - If the opcode is `OP_GO`, set `dest_ID` to `cmd[5:0]` and go to MOVING. Any other opcode: stay in IDLE.
  - When `ID_vld`=1, pulse `clr_ID_vld` and discard the ID (stale IDs are drained).
- MOVING (`in_transit`=1):
  - `cmd_rdy` with `OP_STOP`: pulse `clr_cmd_rdy`, go to IDLE.
  - `cmd_rdy` with `OP_GO`: pulse `clr_cmd_rdy`, reload `dest_ID`, stay in MOVING.
  - `cmd_rdy` with a reserved opcode: pulse `clr_cmd_rdy`, no other effect.
  - `ID_vld` with `ID[7:6]`==2'b00 and `ID[5:0]`==`dest_ID`: pulse `clr_ID_vld`, go to IDLE.
  - `ID_vld` with any other ID: pulse `clr_ID_vld`, stay in MOVING.
- Simultaneous `cmd_rdy` and `ID_vld`: both clear pulses assert in the same cycle. The command is acted on and the ID is discarded without comparison.
- `go` = `in_transit` & `OK2Move`. Clearing `OK2Move` removes `go` but does not change state or `dest_ID`.
- Comparison is an exact 6-bit equality. There is no wrap or arithmetic on IDs.

## Timing
- Reset values: `state`=IDLE, `dest_ID`=0, `in_transit`=0, `go`=0, `clr_cmd_rdy`=0, `clr_ID_vld`=0, `buzz`=0, `buzz_n`=1, divider=0.
- Reset dominates all inputs. When `rst` is asserted mid-transit, the block is in IDLE on the next edge and no clear pulses occur while `rst`=1.
- The clear pulses are Mealy outputs, asserted in the same cycle that `cmd_rdy`/`ID_vld` is sampled high in a state that consumes it.
- Each clear pulse is one cycle wide. The block does not re-consume the same request on the next cycle, because the source drops its valid flag on the clearing edge.
- `in_transit` is registered: it changes one cycle after the accepting edge. `go` follows `in_transit` and `OK2Move` combinationally.
- A matching ID drops `in_transit` and `go` at the edge after `ID_vld` is seen (1-cycle latency).

## Configuration
- `CMD_CNTRL_BUZZ_EN` defined:
  - The divider counts while `in_transit` & !`OK2Move`.
  - `buzz` toggles when the count reaches `BUZZ_DIV`-1, and the count returns to 0.
  - When the condition drops, the divider clears to 0 and `buzz` is forced to 0 on the next edge.
  - `buzz_n` = ~`buzz`.
- `CMD_CNTRL_BUZZ_EN` undefined: `buzz`=0 and `buzz_n`=1 constantly. No divider logic is synthesized and `BUZZ_DIV` is unused.

## Structure
- Package `cmd_cntrl_pkg`: `state_t` enum, `OP_STOP`/`OP_GO` opcode constants, `ID_TAG_STATION`=2'b00.
- Sub-module `buzz_gen` (params `BUZZ_DIV`; ports `clk`, `rst`, `en`, `buzz`, `buzz_n`). It is instantiated only under `CMD_CNTRL_BUZZ_EN`.
- The FSM, `dest_ID` register and handshake logic stay in `cmd_cntrl`.

## Test plan
- **Go command:** reset; `cmd`=8'h45, `cmd_rdy` held → `clr_cmd_rdy` pulses for 1 cycle; next cycle `in_transit`=1 and `dest_ID`=6'h05; with `OK2Move`=1, `go`=1.
- **Non-matching IDs:** in MOVING to 6'h05, `ID`=8'h03 then `ID`=8'h45 (tag ≠ 00) → each gets a `clr_ID_vld` pulse and `in_transit` stays 1. Then `ID`=8'h05 → `clr_ID_vld` pulse, and next cycle `in_transit`=0 and `go`=0.
- **Stop and retarget:** in MOVING, `cmd`=8'h00 → IDLE after 1 cycle. In a separate run, MOVING to 6'h05 then `cmd`=8'h4A → stays in MOVING; `ID`=8'h05 is ignored and `ID`=8'h0A stops.
- **Collision and drain:** `cmd_rdy` and `ID_vld` rise together in MOVING with `cmd`=8'h00 and `ID`=8'h05 → both clears pulse and the state goes to IDLE. In IDLE, `ID_vld` → drained with no state change. Reserved `cmd`=8'hC7 → consumed with no effect.
- **Blocked buzzer:** `BUZZ_DIV`=4, `CMD_CNTRL_BUZZ_EN` defined, MOVING, `OK2Move`=0 → `go`=0 and `buzz` toggles every 4 cycles with `buzz_n` its complement. Setting `OK2Move`=1 → `buzz`=0 next cycle. With the macro undefined, `buzz` stays 0 throughout.
- **Reset mid-transit:** `rst`=1 while MOVING with `ID_vld`=1 → next cycle all outputs are at their reset values and no `clr_ID_vld` pulse occurs while `rst`=1.
